// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative square-root core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sqrt_pkg;

    // Controller states: waiting for an operand, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sqrt_state_e;

    // The root of a WIDTH-bit operand needs half as many bits.
    function automatic int root_w(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/sqrt_iter_hs_if.sv
// Operand/result handshake bundle for the iterative square-root core.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports (signals): in_valid, in_ready, in_data[WIDTH], out_valid, out_ready,
//                  out_root[ROOT_W], out_rem[ROOT_W+1], busy.
interface sqrt_iter_hs_if #(
    parameter int WIDTH = 16
) ();
    localparam int ROOT_W = sqrt_pkg::root_w(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] out_root;
    logic [ROOT_W:0]   out_rem;
    logic              busy;

    // Query source / result consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_root, out_rem, busy
    );

    // Square-root core side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_root, out_rem, busy
    );
endinterface

// File: rtl/sqrt_iter_step.sv
// One restoring square-root iteration: brings in two operand bits, emits one root bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: rem_i[ROOT_W] (running remainder, MSB known zero mid-run), root_i[ROOT_W],
//        bits_i[2] (next operand bit pair), rem_next_o[ROOT_W+1], root_next_o[ROOT_W], taken_o.
module sqrt_iter_step #(
    parameter int ROOT_W = 8
) (
    input  logic [ROOT_W-1:0] rem_i,
    input  logic [ROOT_W-1:0] root_i,
    input  logic [1:0]        bits_i,
    output logic [ROOT_W:0]   rem_next_o,
    output logic [ROOT_W-1:0] root_next_o,
    output logic              taken_o
);
    logic [ROOT_W+1:0] rem_sh;
    logic [ROOT_W+1:0] trial;
    logic [ROOT_W:0]   diff;

    assign rem_sh  = {rem_i, bits_i};
    assign trial   = {root_i, 2'b01};
    assign taken_o = (rem_sh >= trial);

    // When the trial fits, the true difference is <= 2*root, so the low
    // ROOT_W+1 bits of the subtraction are exact.
    assign diff = rem_sh[ROOT_W:0] - trial[ROOT_W:0];

    assign rem_next_o  = taken_o ? diff : rem_sh[ROOT_W:0];
    assign root_next_o = {root_i[ROOT_W-2:0], taken_o};
endmodule

// File: rtl/sqrt_iter_hs.sv
// Iterative integer square root with remainder, one root bit per cycle.
// Latency: out_valid rises WIDTH/2 cycles after the input handshake; accepts at most one operand per WIDTH/2+2 cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready low while busy or holding a result.
// Ports: clk, rst_n (async active-low), bus (sqrt_iter_hs_if.slave: operand in, root/remainder out, busy).
module sqrt_iter_hs
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sqrt_iter_hs_if.slave bus
);
    localparam int ROOT_W = root_w(WIDTH);
    localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("sqrt_iter_hs: WIDTH must be even and >= 4");
        end
    endgenerate

    sqrt_state_e       state_q, state_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [ROOT_W:0]   rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROOT_W-1:0] res_root_q, res_root_d;
    logic [ROOT_W:0]   res_rem_q, res_rem_d;

    logic [ROOT_W:0]   step_rem;
    logic [ROOT_W-1:0] step_root;
    logic              step_taken;

    logic in_ready_c, out_valid_c, busy_c;

    // rem_q MSB is always zero before the last iteration, so only the low
    // ROOT_W bits feed the step.
    sqrt_iter_step #(.ROOT_W(ROOT_W)) u_step (
        .rem_i      (rem_q[ROOT_W-1:0]),
        .root_i     (root_q),
        .bits_i     (op_q[WIDTH-1 -: 2]),
        .rem_next_o (step_rem),
        .root_next_o(step_root),
        .taken_o    (step_taken)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)            state_d = RUN;
            RUN:     if (cnt_q == '0)             state_d = DONE;
            DONE:    if (bus.out_ready)           state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Outputs depend on state only, never on in_valid.
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        unique case (state_q)
            IDLE:    in_ready_c  = 1'b1;
            RUN:     busy_c      = 1'b1;
            DONE:    out_valid_c = 1'b1;
            default: in_ready_c  = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        op_d       = op_q;
        rem_d      = rem_q;
        root_d     = root_q;
        cnt_d      = cnt_q;
        res_root_d = res_root_q;
        res_rem_d  = res_rem_q;
        if (state_q == IDLE && bus.in_valid) begin
            op_d   = bus.in_data;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(ROOT_W - 1);
        end else if (state_q == RUN) begin
            op_d   = {op_q[WIDTH-3:0], 2'b00};
            rem_d  = step_rem;
            root_d = step_root;
            if (cnt_q == '0) begin
                // Separate result registers keep the last answer visible
                // while the next operand is being iterated.
                res_root_d = step_root;
                res_rem_d  = step_rem;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            res_root_q <= '0;
            res_rem_q  <= '0;
        end else begin
            op_q       <= op_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            cnt_q      <= cnt_d;
            res_root_q <= res_root_d;
            res_rem_q  <= res_rem_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.out_root  = res_root_q;
    assign bus.out_rem   = res_rem_q;

    // The appended root bit is the step's taken flag.
    a_taken_lsb: assert property (@(posedge clk) disable iff (!rst_n)
        step_root[0] == step_taken);

    // The remainder never exceeds twice the partial root; this is what lets
    // it live in ROOT_W+1 bits.
    a_rem_bound: assert property (@(posedge clk) disable iff (!rst_n)
        rem_q <= {root_q, 1'b0});
endmodule
